// File: rtl/snn_xor_eval_sequencer.sv
// snn_xor_eval_sequencer: replays buffered config onto the XOR spiking network, runs the four
// input patterns and reports a correctness score plus summed response time.
module snn_xor_eval_sequencer #(
   parameter int ADDR_WIDTH  = 3,
   parameter int CMD_WIDTH   = 3,
   parameter int FLOAT_WIDTH = 8,
   parameter int CFG_DEPTH   = 16,
   parameter int RUN_CYCLES  = 37,
   parameter int TIME_WIDTH  = 34
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cfg_valid,
   output logic                   cfg_ready,
   input  logic [ADDR_WIDTH-1:0]  cfg_addr,
   input  logic [CMD_WIDTH-1:0]   cfg_cmd,
   input  logic [FLOAT_WIDTH-1:0] cfg_arg,
   input  logic                   cfg_flush,
   input  logic                   start,
   output logic [ADDR_WIDTH-1:0]  net_addr,
   output logic [CMD_WIDTH-1:0]   net_cmd,
   output logic [FLOAT_WIDTH-1:0] net_arg,
   output logic                   net_in1,
   output logic                   net_in2,
   input  logic                   net_out,
   input  logic [31:0]            net_out_time,
   output logic                   busy,
   output logic                   done,
   output logic [2:0]             score,
   output logic [TIME_WIDTH-1:0]  time_sum,
   output logic [3:0]             pattern_out
);
   localparam int CW = $clog2(CFG_DEPTH);
   localparam int RW = $clog2(RUN_CYCLES + 1);
   typedef enum logic [2:0] {IDLE, LOAD, CLEAR, RUN, SAMPLE, DONE} state_t;
   state_t                 state;
   logic [ADDR_WIDTH-1:0]  f_addr [CFG_DEPTH];
   logic [CMD_WIDTH-1:0]   f_cmd  [CFG_DEPTH];
   logic [FLOAT_WIDTH-1:0] f_arg  [CFG_DEPTH];
   logic [CW:0]            count;
   logic [CW-1:0]          idx;
   logic [RW-1:0]          run_cnt;
   logic [1:0]             pat;
   logic                   o;
   logic                   wr;
   assign cfg_ready = (state == IDLE) && (count != (CW+1)'(CFG_DEPTH));
   assign wr = cfg_valid && cfg_ready && !cfg_flush;
   assign o = (net_out === 1'b1);
   always_ff @(posedge clk)
      if (wr) begin
         f_addr[count[CW-1:0]] <= cfg_addr;
         f_cmd[count[CW-1:0]] <= cfg_cmd;
         f_arg[count[CW-1:0]] <= cfg_arg;
      end
   // Network-facing outputs are registered from the current state, so they trail it by one cycle.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         count <= '0;
         idx <= '0;
         run_cnt <= '0;
         pat <= '0;
         net_addr <= '0;
         net_cmd <= CMD_WIDTH'(1);
         net_arg <= '0;
         net_in1 <= 1'b0;
         net_in2 <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
         score <= '0;
         time_sum <= '0;
         pattern_out <= '0;
      end else begin
         busy <= state != IDLE;
         done <= state == DONE;
         net_addr <= state == LOAD ? f_addr[idx] : '0;
         net_arg <= state == LOAD ? f_arg[idx] : '0;
         net_cmd <= state == LOAD ? f_cmd[idx] : state == CLEAR ? CMD_WIDTH'(5) :
                    state == RUN ? '0 : CMD_WIDTH'(1);
         {net_in1, net_in2} <= (state == CLEAR || state == RUN || state == SAMPLE) ? pat : 2'b00;
         case (state)
            IDLE: begin
               count <= cfg_flush ? '0 : wr ? count + 1'b1 : count;
               if (start) begin
                  score <= '0;
                  time_sum <= '0;
                  pattern_out <= '0;
                  pat <= '0;
                  idx <= '0;
                  state <= count != '0 ? LOAD : CLEAR;
               end
            end
            LOAD: begin
               idx <= idx + 1'b1;
               if ({1'b0, idx} == count - 1'b1) state <= CLEAR;
            end
            CLEAR: begin
               run_cnt <= '0;
               state <= RUN;
            end
            RUN: begin
               run_cnt <= run_cnt + 1'b1;
               if (run_cnt == RW'(RUN_CYCLES - 1)) state <= SAMPLE;
            end
            SAMPLE: begin
               pattern_out[pat] <= o;
               time_sum <= time_sum + TIME_WIDTH'(net_out_time);
               if (o == (pat[1] ^ pat[0])) score <= score + 3'd1;
               pat <= pat + 2'd1;
               state <= pat == 2'd3 ? DONE : CLEAR;
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_snn_xor_eval_sequencer.sv
// tb_snn_xor_eval_sequencer: scoreboard bench with a behavioural XOR network model.
module tb_snn_xor_eval_sequencer;
   localparam int TW = 34;
   localparam int D = 16;
   localparam int RC = 37;
   logic clk = 0, rst = 1;
   logic cfg_valid = 0, cfg_flush = 0, start = 0;
   logic [2:0] cfg_addr = 0, cfg_cmd = 0;
   logic [7:0] cfg_arg = 0;
   logic cfg_ready, net_in1, net_in2, busy, done;
   logic [2:0] net_addr, net_cmd, score;
   logic [7:0] net_arg;
   logic [TW-1:0] time_sum;
   logic [3:0] pattern_out;
   wire net_out;
   logic [31:0] net_out_time;
   logic [3:0] spike_mask = 0;
   logic [31:0] spike_t = 0, ncnt = 0;
   logic zmode = 1;
   wire [1:0] pat_i = {net_in1, net_in2};
   int cyc = 0, checks = 0, failures = 0;
   typedef struct {logic [2:0] sc; logic [3:0] po; logic [TW-1:0] ts; int lat;} exp_t;
   exp_t exp_q[$];
   exp_t x;
   logic [13:0] load_q[$], cfg_m[$];
   logic [13:0] e;

   snn_xor_eval_sequencer dut (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
      .cfg_cmd(cfg_cmd), .cfg_arg(cfg_arg), .cfg_flush(cfg_flush), .start(start),
      .net_addr(net_addr), .net_cmd(net_cmd), .net_arg(net_arg), .net_in1(net_in1),
      .net_in2(net_in2), .net_out(net_out), .net_out_time(net_out_time), .busy(busy),
      .done(done), .score(score), .time_sum(time_sum), .pattern_out(pattern_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) ncnt <= net_cmd == 3'd5 ? 0 : net_cmd == 3'd0 ? ncnt + 1 : ncnt;
   assign net_out = (spike_mask[pat_i] && ncnt >= spike_t) ? 1'b1 : zmode ? 1'bz : 1'b0;
   assign net_out_time = spike_mask[pat_i] ? spike_t : 32'd45;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
      checks++;
      if (obs !== want) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", tag, obs, want);
      end
   endtask

   always @(negedge clk)
      if (!rst) begin
         if (busy && (net_cmd == 3'd6 || net_cmd == 3'd7)) begin
            if (load_q.size() == 0) check("load_extra", {net_addr, net_cmd, net_arg}, 14'h0);
            else begin
               e = load_q.pop_front();
               check("load_entry", {net_addr, net_cmd, net_arg}, e);
            end
         end
         if (done) begin
            if (exp_q.size() == 0) check("unexpected_done", done, 0);
            else begin
               x = exp_q.pop_front();
               check("score", score, x.sc);
               check("pattern_out", pattern_out, x.po);
               check("time_sum", time_sum, x.ts);
               check("done_cycle", cyc, x.lat);
            end
         end
      end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_cmd"}, net_cmd, 1);
      check({tag, "_addr_arg"}, {net_addr, net_arg}, 0);
      check({tag, "_in"}, {net_in1, net_in2}, 0);
      check({tag, "_results"}, {score, pattern_out, time_sum}, 0);
   endtask

   task automatic push_cfg(input logic [2:0] a, input logic [2:0] c, input logic [7:0] g);
      @(negedge clk);
      check("cfg_ready", cfg_ready, cfg_m.size() < D);
      cfg_valid = 1; cfg_addr = a; cfg_cmd = c; cfg_arg = g;
      @(negedge clk);
      cfg_valid = 0;
      if (cfg_m.size() < D) cfg_m.push_back({a, c, g});
   endtask

   task automatic run_eval(input logic [2:0] sc, input logic [3:0] po, input logic [TW-1:0] ts,
                           input logic [3:0] mask, input logic [31:0] t, input logic z, input bit poke);
      int k;
      logic [13:0] first;
      spike_mask = mask; spike_t = t; zmode = z;
      first = cfg_m.size() != 0 ? cfg_m[0] : 14'h0500;
      @(negedge clk);
      start = 1;
      foreach (cfg_m[i]) load_q.push_back(cfg_m[i]);
      @(negedge clk);
      start = 0;
      k = cyc;
      exp_q.push_back('{sc, po, ts, k + cfg_m.size() + 4 * (RC + 2) + 1});
      @(negedge clk);
      check("first_busy", busy, 1);
      check("first_cmd", net_cmd, first[10:8]);
      for (int i = 0; i < 1000 && exp_q.size() != 0; i++) begin
         start = poke && i == 50;
         cfg_valid = poke && i == 50;
         cfg_addr = 3'd7; cfg_cmd = 3'd6; cfg_arg = 8'hee;
         if (poke && i == 50) check("busy_ready", cfg_ready, 0);
         @(negedge clk);
      end
      start = 0; cfg_valid = 0;
      if (exp_q.size() != 0) begin
         check("done_timeout", exp_q.size(), 0);
         exp_q.delete();
      end
      check("done_pulse", done, 0);
      check("load_left", load_q.size(), 0);
      load_q.delete();
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      check("rst_ready", cfg_ready, 1);
      rst = 0;
      run_eval(3'd4, 4'b0110, 114, 4'b0110, 12, 1, 0);
      push_cfg(3'd1, 3'd7, 8'h11);
      push_cfg(3'd2, 3'd6, 8'h22);
      push_cfg(3'd3, 3'd7, 8'h33);
      run_eval(3'd4, 4'b0110, 114, 4'b0110, 12, 1, 0);
      run_eval(3'd2, 4'b1111, 40, 4'b1111, 10, 0, 0);
      run_eval(3'd2, 4'b1111, 40, 4'b1111, 10, 1, 1);
      repeat (3) @(negedge clk);
      check("idle_after_poke", busy, 0);
      run_eval(3'd4, 4'b0110, 114, 4'b0110, 12, 0, 0);
      @(negedge clk);
      cfg_flush = 1; cfg_valid = 1; cfg_addr = 3'd5; cfg_cmd = 3'd7; cfg_arg = 8'h55;
      @(negedge clk);
      cfg_flush = 0; cfg_valid = 0;
      cfg_m.delete();
      run_eval(3'd2, 4'b1111, 40, 4'b1111, 10, 0, 0);
      for (int i = 0; i < 17; i++) push_cfg(3'(i), (i % 2) ? 3'd7 : 3'd6, 8'(i * 7 + 1));
      check("full_ready", cfg_ready, 0);
      run_eval(3'd4, 4'b0110, 114, 4'b0110, 12, 1, 0);
      @(negedge clk);
      start = 1;
      foreach (cfg_m[i]) load_q.push_back(cfg_m[i]);
      @(negedge clk);
      start = 0;
      begin
         int n;
         for (n = 0; n < 2000 && !(net_cmd == 3'd0 && pat_i == 2'b10); n++) @(negedge clk);
         if (n == 2000) check("run_p2_timeout", n, 0);
      end
      repeat (5) @(negedge clk);
      rst = 1;
      #1;
      check_reset_outputs("async_rst");
      repeat (3) @(negedge clk);
      check("rst_hold_done", done, 0);
      rst = 0;
      exp_q.delete(); load_q.delete(); cfg_m.delete();
      repeat (5) @(negedge clk);
      check("post_rst_idle", busy, 0);
      run_eval(3'd4, 4'b0110, 114, 4'b0110, 12, 1, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
